// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling tick positions
// and the even-parity convention used by both transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic [3:0] MID_TICK = 4'd7;
    localparam logic [3:0] END_TICK = 4'd15;

    // Even parity: the parity bit makes the total number of ones even.
    function automatic logic even_parity_bit(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Host-side and line-side signals of the UART receiver, grouped for port use.
interface uart_rx_deframer_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 Rx_EN;
    logic                 RxD;
    logic                 Rx_sample_ENABLE;
    logic [DATA_BITS-1:0] Rx_DATA;
    logic                 Rx_VALID;
    logic                 Rx_FERROR;
    logic                 Rx_PERROR;

    modport master (
        output Rx_EN, RxD, Rx_sample_ENABLE,
        input  Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR
    );

    modport slave (
        input  Rx_EN, RxD, Rx_sample_ENABLE,
        output Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR
    );
endinterface

// File: rtl/rx_sample_counter.sv
// Oversampling tick counter: advances on each sample strobe, wraps to zero,
// and flags the strobe on which it wraps.
module rx_sample_counter
    import uart_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (tick_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = tick_i && (count_q == WIDTH'(END_TICK));

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: recovers start/data/even-parity/stop frames from a
// 16x oversampled serial line and reports data with validity and error status.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                clk,
    input  logic                reset,
    uart_rx_deframer_if.slave   rx_if
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = 3;

    rx_state_t            state_q, state_d;
    logic [1:0]           sync_q;
    logic                 rxd_s;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;

    logic                 tick;
    logic                 cnt_clr;
    logic [CNT_W-1:0]     cnt;
    logic                 end_hit;
    logic                 mid_hit;
    logic                 perr_calc;

    assign tick    = rx_if.Rx_sample_ENABLE;
    assign rxd_s   = sync_q[1];
    assign mid_hit = tick && (cnt == CNT_W'(MID_TICK));

    rx_sample_counter #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .tick_i  (tick),
        .clr_i   (cnt_clr),
        .count_o (cnt),
        .wrap_o  (end_hit)
    );

    assign perr_calc = even_parity_bit(8'(shreg_q)) ^ par_q;

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = ferr_q;
        perr_d    = perr_q;
        cnt_clr   = 1'b0;

        if (!rx_if.Rx_EN) begin
            // Disabled receiver drops any partial frame; last data word is kept.
            state_d = IDLE;
            cnt_clr = 1'b1;
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_clr = 1'b1;
                    if (tick && !rxd_s) begin
                        state_d = START;
                    end
                end
                START: begin
                    if (mid_hit) begin
                        if (!rxd_s) begin
                            cnt_clr   = 1'b1;
                            bit_idx_d = '0;
                            valid_d   = 1'b0;
                            ferr_d    = 1'b0;
                            perr_d    = 1'b0;
                            state_d   = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (end_hit) begin
                        shreg_d   = {rxd_s, shreg_q[DATA_BITS-1:1]};
                        bit_idx_d = bit_idx_q + 1'b1;
                        if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (end_hit) begin
                        par_d   = rxd_s;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop gives half a bit to catch a back-to-back start.
                    if (end_hit) begin
                        data_d  = shreg_q;
                        perr_d  = perr_calc;
                        ferr_d  = ~rxd_s;
                        valid_d = ~perr_calc & rxd_s;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[0], rx_if.RxD};
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
        end
    end

    assign rx_if.Rx_DATA   = data_q;
    assign rx_if.Rx_VALID  = valid_q;
    assign rx_if.Rx_FERROR = ferr_q;
    assign rx_if.Rx_PERROR = perr_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: table of frames plus hand-written
// sequences for glitch, back-to-back, reset and enable corner cases.
module tb_uart_rx_deframer;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    uart_rx_deframer_if #(.DATA_BITS(8)) bus ();

    uart_rx_deframer #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx_if (bus.slave)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] e_data;
        logic       e_valid;
        logic       e_ferr;
        logic       e_perr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sample strobe: one clk high out of every four, changed on falling edges.
    initial begin
        bus.Rx_sample_ENABLE = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            bus.Rx_sample_ENABLE = 1'b1;
            @(negedge clk);
            bus.Rx_sample_ENABLE = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm, input logic [7:0] d, input logic v,
                             input logic f, input logic p);
        chk({nm, ".data"},  {24'b0, bus.Rx_DATA},   {24'b0, d});
        chk({nm, ".valid"}, {31'b0, bus.Rx_VALID},  {31'b0, v});
        chk({nm, ".ferr"},  {31'b0, bus.Rx_FERROR}, {31'b0, f});
        chk({nm, ".perr"},  {31'b0, bus.Rx_PERROR}, {31'b0, p});
        $display("%s: data=%02h valid=%0b ferr=%0b perr=%0b", nm,
                 bus.Rx_DATA, bus.Rx_VALID, bus.Rx_FERROR, bus.Rx_PERROR);
    endtask

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (bus.Rx_sample_ENABLE) k++;
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.RxD = b;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.RxD = 1'b1;
        bus.Rx_EN = 1'b1;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hFE, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{8'h7F, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0};

        repeat (5) @(negedge clk);
        check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);

        for (int i = 0; i < 6; i++) begin
            $display("vector %0d: send data=%02h par=%0b stop=%0b", i,
                     vecs[i].data, vecs[i].par, vecs[i].stop);
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
            check_out($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_valid,
                      vecs[i].e_ferr, vecs[i].e_perr);
            send_bit(1'b1);
            send_bit(1'b1);
        end

        // Status holds while the line idles.
        wait_ticks(32);
        check_out("hold", 8'h7F, 1'b1, 1'b0, 1'b0);

        // Back-to-back 0xFF then 0x00 with no extra idle.
        send_frame(8'hFF, 1'b0, 1'b1);
        check_out("b2b_first", 8'hFF, 1'b1, 1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        check_out("b2b_cleared", 8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i < 8; i++) send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        check_out("b2b_second", 8'h00, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1);

        // Short low pulse must be rejected without touching status.
        @(negedge clk);
        bus.RxD = 1'b0;
        wait_ticks(5);
        @(negedge clk);
        bus.RxD = 1'b1;
        wait_ticks(20);
        check_out("glitch", 8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1);
        check_out("after_glitch", 8'h5A, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1);

        // Reset during the data phase.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        @(negedge clk);
        reset = 1'b1;
        bus.RxD = 1'b1;
        @(negedge clk);
        check_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        send_bit(1'b1);
        send_frame(8'h81, 1'b0, 1'b1);
        check_out("post_reset", 8'h81, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1);

        // Disable while idle with valid status.
        @(negedge clk);
        bus.Rx_EN = 1'b0;
        @(negedge clk);
        check_out("en_idle", 8'h81, 1'b0, 1'b0, 1'b0);
        bus.Rx_EN = 1'b1;
        send_bit(1'b1);

        // Disable mid-frame with the line low.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        bus.Rx_EN = 1'b0;
        @(negedge clk);
        check_out("en_midframe", 8'h81, 1'b0, 1'b0, 1'b0);
        bus.RxD = 1'b1;
        repeat (4) @(negedge clk);
        bus.Rx_EN = 1'b1;
        wait_ticks(200);
        check_out("en_no_spurious", 8'h81, 1'b0, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b1);
        check_out("en_recover", 8'h33, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side counterpart of the UART transmitter.
- Recovers 8N-E1 frames (start bit, DATA_BITS data bits LSB first, even parity bit, stop bit) from the serial line RxD.
- Runs off the shared baud controller's 16x oversampling strobe Rx_sample_ENABLE.
- Presents the received byte with valid, framing-error and parity-error status to the host side.

Parameters:
DATA_BITS, 8, data bits per frame (legal 5..8)
OVERSAMPLE, 16, sample strobes per bit period; mid-bit is tick OVERSAMPLE/2-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
Rx_EN  in  1  receiver enable; low forces IDLE and holds status cleared
RxD  in  1  asynchronous serial input, idle high
Rx_sample_ENABLE  in  1  one-clk strobe, 16 per bit period, from baud controller
Rx_DATA  out  DATA_BITS  last received data word
Rx_VALID  out  1  frame received with no errors
Rx_FERROR  out  1  stop bit sampled low
Rx_PERROR  out  1  even-parity mismatch

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- On reset: state IDLE; sample counter, bit index and shift register = 0; synchronizer = 2'b11; Rx_DATA = 0; Rx_VALID = Rx_FERROR = Rx_PERROR = 0.
- RxD passes through a 2-FF synchronizer (rxd_s). All decisions use rxd_s, so line-to-decision latency is 2 clk plus tick alignment.
- The 4-bit sample counter advances only on clk edges where Rx_sample_ENABLE = 1 and wraps 15->0. All state transitions happen only on tick cycles, except the Rx_EN exit.
- IDLE: on a tick with rxd_s = 0, go to START and set counter = 0.
- START: on the tick where counter = 7 (mid-bit):
  - rxd_s = 0: confirmed start. Clear counter, bit index and all three status flags; go to DATA.
  - rxd_s = 1: glitch. Return to IDLE; status flags untouched.
- DATA: on each tick with counter = 15, shift rxd_s in LSB first (shreg <= {rxd_s, shreg[DATA_BITS-1:1]}) and increment the bit index. After bit index DATA_BITS-1, go to PARITY.
- PARITY: on the tick with counter = 15, capture rxd_s as the parity bit and go to STOP.
- STOP: on the tick with counter = 15:
  - Rx_DATA <= shreg, unconditionally.
  - Rx_PERROR <= XOR(shreg, parity bit) (1 = odd total = error).
  - Rx_FERROR <= ~rxd_s.
  - Rx_VALID <= 1 only if both errors are 0.
  - Go to IDLE. Mid-stop exit leaves half a bit period to detect a back-to-back start.
- Status flags and Rx_DATA hold until the next confirmed start bit, reset, or Rx_EN = 0. The host reads them at leisure.
- Rx_EN = 0, any state, any cycle: next clk forces IDLE, counter = 0, all three status flags = 0. Rx_DATA holds.
- Rx_EN rising: no frame is accepted until rxd_s has been sampled at a tick. An in-progress low line is treated as a new start candidate and is qualified by the mid-bit check.
- Reset mid-frame: immediate return to the reset values above; the partial frame is discarded.
- Rx_sample_ENABLE is never high on two consecutive clk cycles in normal operation. If it is, the block still counts every strobe.
- A break condition (line held low) yields a frame of 0x00 with Rx_FERROR = 1. The block then re-enters START as soon as it is back in IDLE and the line is still low.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants: IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  - MID_TICK = 7 and END_TICK = 15;
  - the even-parity convention, shared with the transmitter.
- One natural sub-module: rx_sample_counter (4-bit tick counter with synchronous clear and a wrap flag). It mirrors the transmitter's counters.
- The FSM, bit index, shift register and status registers live in the top.

Test Plan:
- Bench setup: Rx_sample_ENABLE pulses every 4th clk; 1 bit = 16 ticks; Rx_EN = 1.
- Frame 0xA5 (four 1s, parity 0, stop 1) -> Rx_DATA = 8'hA5, Rx_VALID = 1, Rx_FERROR = 0, Rx_PERROR = 0, asserted at mid-stop tick. Flags stay asserted until the next confirmed start.
- Frame 0x01 with parity bit 0 (should be 1) -> Rx_DATA = 8'h01, Rx_PERROR = 1, Rx_VALID = 0. Frame 0x3C with stop bit 0 -> Rx_FERROR = 1, Rx_VALID = 0.
- RxD low for 5 ticks then high (glitch) -> back to IDLE at tick 7, no status change. A following good frame 0x5A is received correctly.
- Back-to-back frames 0xFF then 0x00, with no idle gap beyond the stop bit -> both received. Status is cleared at the second frame's confirmed start, then Rx_DATA = 8'h00, Rx_VALID = 1.
- Reset asserted in DATA after 3 bits, then released, then full frame 0x81 -> outputs zero during reset; 0x81 received with Rx_VALID = 1.
- Rx_EN dropped mid-frame -> IDLE next clk, all flags 0, Rx_DATA keeps the previous value (0x81).
